// File: rtl/data_mem_bank.sv
// Word-organised data memory with byte/half/word access, self-clearing after reset.
// Optional debug read port for word DBG_WORD when DMEM_DEBUG_PORT_EN is defined.
module data_mem_bank #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned DBG_WORD    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
`ifdef DMEM_DEBUG_PORT_EN
  ,
  output logic [31:0]       dbg_rdata
`endif
);

  localparam int unsigned MemAw = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  if (DBG_WORD >= DEPTH_WORDS) begin : g_dbg_word_check
    $error("DBG_WORD must be below DEPTH_WORDS");
  end

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e           state_q, state_d;
  logic [MemAw-1:0] clr_idx_q, clr_idx_d;
  logic [31:0]      mem [DEPTH_WORDS];

  logic              rsp_valid_q, rsp_err_q;
  logic [31:0]       rsp_rdata_q;

  logic [ADDR_W-3:0] word_idx;
  logic [MemAw-1:0]  mem_idx;
  logic              in_range, aligned, legal, accept;
  logic [31:0]       rd_word, load_data, wr_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [3:0]        wr_be;

  assign word_idx = req_addr[ADDR_W-1:2];
  assign mem_idx  = MemAw'(word_idx);
  assign in_range = 32'(word_idx) < DEPTH_WORDS;
  assign accept   = req_valid & req_ready;

  always_comb begin
    aligned = 1'b0;
    case (req_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~req_addr[0];
      2'b10:   aligned = (req_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    legal = aligned & in_range;
  end

  // Asynchronous read: a store committed at the previous edge is already visible here.
  assign rd_word = mem[mem_idx];
  assign rd_byte = rd_word[{req_addr[1:0], 3'b000} +: 8];
  assign rd_half = rd_word[{req_addr[1], 4'b0000} +: 16];

  always_comb begin
    load_data = rd_word;
    case (req_size)
      2'b00:   load_data = {{24{~req_unsigned & rd_byte[7]}}, rd_byte};
      2'b01:   load_data = {{16{~req_unsigned & rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    wr_be   = 4'b0000;
    wr_word = req_wdata;
    case (req_size)
      2'b00: begin
        wr_be   = 4'b0001 << req_addr[1:0];
        wr_word = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{req_wdata[15:0]}};
      end
      2'b10: wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  // Memory has no reset; the clear sequence zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem[clr_idx_q] <= '0;
    end else if (accept && req_we && legal) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[mem_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      StClear: begin
        if (clr_idx_q == MemAw'(DEPTH_WORDS - 1)) begin
          state_d   = StReady;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      StReady: state_d = StReady;
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StClear;
      clr_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      rsp_valid_q <= accept & ~req_we & legal;
      rsp_err_q   <= accept & ~legal;
      if (accept && !req_we && legal) rsp_rdata_q <= load_data;
    end
  end

  assign req_ready = (state_q == StReady);
  assign busy      = (state_q == StClear);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef DMEM_DEBUG_PORT_EN
  assign dbg_rdata = mem[MemAw'(DBG_WORD)];
`endif

endmodule

// File: tb/tb_data_mem_bank.sv
// Directed self-checking bench for data_mem_bank (default parameters).
// Also checks dbg_rdata when built with DMEM_DEBUG_PORT_EN.
module tb_data_mem_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [13:0] req_addr = '0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
`ifdef DMEM_DEBUG_PORT_EN
  logic [31:0] dbg_rdata;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_bank dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy)
`ifdef DMEM_DEBUG_PORT_EN
    ,
    .dbg_rdata    (dbg_rdata)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one edge; outputs are sampled right after.
  task automatic issue(input logic we, input logic [13:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    tick();
    req_valid    = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (req_ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != 1024) begin
      n_fail++;
      $display("FAIL %s: clear took %0d cycles, expected 1024", name, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({busy, req_ready, rsp_valid, rsp_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: got busy/ready/valid/err=%b expected 1000",
               {busy, req_ready, rsp_valid, rsp_err});
    end
    n_checks++;
    if (rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h expected 00000000", rsp_rdata);
    end
    rst_n = 1'b1;
    wait_ready("reset_release");
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_busy: got %b expected 0", busy);
    end
    issue(1'b0, 14'h0010, 2'b10, 1'b0, 32'h0);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL cleared_load: got valid=%b data=%h expected 1 00000000",
               rsp_valid, rsp_rdata);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_pulse: got valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_byte_lanes();
    issue(1'b1, 14'h0000, 2'b10, 1'b0, 32'h9F5D4A6E);
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL store_no_rsp: got valid=%b err=%b expected 0 0", rsp_valid, rsp_err);
    end
    issue(1'b1, 14'h0002, 2'b00, 1'b0, 32'hAAAAAA11);
    issue(1'b0, 14'h0000, 2'b10, 1'b0, 32'h0);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h9F114A6E) begin
      n_fail++;
      $display("FAIL byte_lane: got valid=%b data=%h expected 1 9f114a6e", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_extension();
    logic [13:0] addrs [6] = '{14'h3, 14'h3, 14'h0, 14'h2, 14'h2, 14'h1};
    logic [1:0]  sizes [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    logic        unss  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exps  [6] = '{32'hFFFFFF9F, 32'h0000009F, 32'h00004A6E,
                               32'hFFFF9F11, 32'h00009F11, 32'h0000004A};
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, addrs[i], sizes[i], unss[i], 32'h0);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exps[i]) begin
        n_fail++;
        $display("FAIL extend_%0d: got valid=%b data=%h expected 1 %h",
                 i, rsp_valid, rsp_rdata, exps[i]);
      end
    end
  endtask

  task automatic test_misalign();
    logic [13:0] bad_addr [3] = '{14'h0001, 14'h0000, 14'h1000};
    logic [1:0]  bad_size [3] = '{2'b01, 2'b11, 2'b10};
    issue(1'b1, 14'h0004, 2'b10, 1'b0, 32'h11111111);
    issue(1'b1, 14'h0008, 2'b10, 1'b0, 32'h22222222);
    issue(1'b0, 14'h0008, 2'b10, 1'b0, 32'h0);
    issue(1'b1, 14'h0006, 2'b10, 1'b0, 32'hDEADBEEF);
    n_checks++;
    if ({rsp_err, rsp_valid} !== 2'b10 || rsp_rdata !== 32'h22222222) begin
      n_fail++;
      $display("FAIL misalign_store: got err/valid=%b data=%h expected 10 22222222",
               {rsp_err, rsp_valid}, rsp_rdata);
    end
    tick();
    n_checks++;
    if (rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse: got err=%b expected 0", rsp_err);
    end
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, bad_addr[i], bad_size[i], 1'b0, 32'h0);
      n_checks++;
      if ({rsp_err, rsp_valid} !== 2'b10) begin
        n_fail++;
        $display("FAIL illegal_load_%0d: got err/valid=%b expected 10", i, {rsp_err, rsp_valid});
      end
    end
    issue(1'b0, 14'h0004, 2'b10, 1'b0, 32'h0);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11111111) begin
      n_fail++;
      $display("FAIL word4_kept: got valid=%b data=%h expected 1 11111111", rsp_valid, rsp_rdata);
    end
    issue(1'b0, 14'h0008, 2'b10, 1'b0, 32'h0);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h22222222) begin
      n_fail++;
      $display("FAIL word8_kept: got valid=%b data=%h expected 1 22222222", rsp_valid, rsp_rdata);
    end
    issue(1'b1, 14'h000A, 2'b01, 1'b0, 32'h5555BEEF);
    issue(1'b0, 14'h0008, 2'b10, 1'b0, 32'h0);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hBEEF2222) begin
      n_fail++;
      $display("FAIL half_store: got valid=%b data=%h expected 1 beef2222", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 14'h0014, 2'b10, 1'b0, 32'h0000000A);
    issue(1'b0, 14'h0014, 2'b10, 1'b0, 32'h0);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000000A || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back: got valid=%b data=%h ready=%b expected 1 0000000a 1",
               rsp_valid, rsp_rdata, req_ready);
    end
`ifdef DMEM_DEBUG_PORT_EN
    n_checks++;
    if (dbg_rdata !== 32'h0000000A) begin
      n_fail++;
      $display("FAIL dbg_rdata: got %h expected 0000000a", dbg_rdata);
    end
`endif
  endtask

  task automatic test_reset_mid_ready();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 14'h0014;
    req_size  = 2'b10;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    req_valid = 1'b0;
    n_checks++;
    if ({busy, req_ready, rsp_valid} !== 3'b100 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got busy/ready/valid=%b data=%h expected 100 00000000",
               {busy, req_ready, rsp_valid}, rsp_rdata);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < 500; i++) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_mid_clear: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_ready("reclear_after_pulse");
    issue(1'b0, 14'h0014, 2'b10, 1'b0, 32'h0);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reclear_word5: got valid=%b data=%h expected 1 00000000", rsp_valid, rsp_rdata);
    end
    issue(1'b0, 14'h0000, 2'b10, 1'b0, 32'h0);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reclear_word0: got valid=%b data=%h expected 1 00000000", rsp_valid, rsp_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_extension();
    test_misalign();
    test_back_to_back();
    test_reset_mid_ready();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_bank.md
DATA_MEM_BANK -- requirements
Module: data_mem_bank

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, byte-address width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words; the word index is addr[ADDR_W-1:2].
REQ-003 SHALL have parameter DBG_WORD, default 5, word index exposed on the debug port.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, 1, access request.
REQ-007 SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready.
REQ-008 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port req_addr, input, ADDR_W, byte address.
REQ-010 SHALL have port req_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-011 SHALL have port req_unsigned, input, 1, zero-extend loads when 1, sign-extend when 0.
REQ-012 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-013 SHALL have port rsp_valid, output, 1, one-cycle load-response pulse.
REQ-014 SHALL have port rsp_rdata, output, 32, extended load data.
REQ-015 SHALL have port rsp_err, output, 1, one-cycle error pulse.
REQ-016 SHALL have port busy, output, 1, high while the clear sequence runs.

Function
REQ-017 SHALL implement a two-state FSM: CLEAR and READY.
- CLEAR: writes 0 to word clr_idx, incrementing clr_idx by 1 each cycle from 0.
- CLEAR to READY: after writing word DEPTH_WORDS-1, i.e. exactly DEPTH_WORDS cycles after rst_n deasserts.
REQ-018 SHALL drive req_ready = 0 and busy = 1 in CLEAR, and req_ready = 1 and busy = 0 in READY.
REQ-019 SHALL register an accepted legal load and assert rsp_valid with rsp_rdata exactly 1 cycle after acceptance.
- rsp_rdata holds its value until the next load response.
REQ-020 SHALL extend load data as follows:
- Byte: select lane addr[1:0]; extend bit 7.
- Half: select lane addr[1]; extend bit 15.
- Extension is zero when req_unsigned = 1, sign otherwise.
REQ-021 SHALL perform an accepted legal store at the acceptance edge with per-lane byte enables:
- Byte: lane addr[1:0].
- Half: lanes {addr[1],0} and {addr[1],1}.
- Word: all lanes.
- Unselected bytes are unchanged.
- No rsp_valid is generated for stores.
REQ-022 SHALL treat the following as illegal: req_size = 11; half with addr[0] = 1; word with addr[1:0] != 00; word index >= DEPTH_WORDS.
REQ-023 SHALL NOT modify memory on an illegal access; it pulses rsp_err 1 cycle after acceptance (load or store), with rsp_valid = 0 and rsp_rdata unchanged.
REQ-024 SHALL return the newly written data for a load accepted the cycle after a store to the same word.
REQ-025 SHALL accept one request per cycle in READY with no bubbles.

Reset
REQ-026 SHALL, while rst_n = 0, asynchronously force: FSM to CLEAR; clr_idx = 0; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0; req_ready = 0; busy = 1.
REQ-027 SHALL restart the clear sequence from word 0 if reset asserts mid-CLEAR or mid-READY; in-flight responses are discarded.

Configuration
REQ-028 SHALL, when DMEM_DEBUG_PORT_EN is defined, add output dbg_rdata (32 bits) driven combinationally from word DBG_WORD.
REQ-029 SHALL, when DMEM_DEBUG_PORT_EN is undefined, have no dbg_rdata port and no related logic.

Verification
REQ-030 SHALL cover reset release: busy = 1 for 1024 cycles, then req_ready = 1, and a word load of addr 0x0010 returns 0x00000000.
REQ-031 SHALL cover byte lanes: store word 0x9F5D4A6E to 0x0000, then store byte 0x11 to 0x0002, then load word 0x0000 -> 0x9F114A6E.
REQ-032 SHALL cover load extension:
- Load byte signed at 0x0003 -> 0xFFFFFF9F.
- Load byte unsigned at 0x0003 -> 0x0000009F.
- Load half signed at 0x0000 -> 0x00004A6E.
REQ-033 SHALL cover misalignment: word store to 0x0006 -> rsp_err pulse 1 cycle later, and words 0x0004 and 0x0008 are unchanged.
REQ-034 SHALL cover back-to-back traffic: store word 0x0000000A to 0x0014, then on the next cycle load word 0x0014 -> rsp_valid with 0x0000000A; with DMEM_DEBUG_PORT_EN defined, dbg_rdata = 0x0000000A.
REQ-035 SHALL cover reset mid-clear: rst_n pulsed low at clear cycle 500 -> busy stays high a further full 1024 cycles after release.
